// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//   Single-clock FIFO controller with storage. It supports any depth >= 2
//   (power of two or not), an occupancy count, almost-full/almost-empty
//   thresholds, registered or first-word-fall-through read data, and one-cycle
//   overflow/underflow event pulses.
//
// Parameters
//   DATA_W     data word width
//   DEPTH      number of storage entries (>= 2)
//   AF_THRESH  almost_full when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when level <= AE_THRESH (0..DEPTH-1)
//   FWFT       0 = registered read data, 1 = first-word-fall-through
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   wr_fire, wr_data         write request and data
//   full, almost_full        level decodes (combinational from level register)
//   overflow                 pulse: a write was dropped because the FIFO was full
//   rd_fire, rd_data         read request and data
//   empty, almost_empty      level decodes (combinational from level register)
//   underflow                pulse: a read was refused because the FIFO was empty
//   level                    current occupancy
//   stats_clr                clears peak_level and drop_cnt
//   peak_level, drop_cnt     occupancy high-water mark, dropped/refused count
//
// Optional feature macro: SYNC_FIFO_STATS_EN
//   Defined   -> peak_level / drop_cnt statistics are built.
//   Undefined -> peak_level and drop_cnt read 0 and stats_clr is ignored.
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATA_W    = 65,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_fire,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       rd_fire,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       stats_clr,
    output logic [$clog2(DEPTH+1)-1:0] peak_level,
    output logic [15:0]                drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              overflow_r;
    logic              underflow_r;

    logic              full_s;
    logic              empty_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ovf_ev_s;
    logic              unf_ev_s;

    assign full_s   = (level_r == LVL_FULL);
    assign empty_s  = (level_r == {LVL_W{1'b0}});

    // Acceptance is judged on the flags as they stand before the edge, so a
    // simultaneous read never makes room for a write into a full FIFO, and a
    // simultaneous write never satisfies a read from an empty one.
    assign wr_acc_s = wr_fire && !full_s;
    assign rd_acc_s = rd_fire && !empty_s;
    assign ovf_ev_s = wr_fire && full_s;
    assign unf_ev_s = rd_fire && empty_s;

    // Next occupancy from the accepted-operation pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            level_r     <= level_nxt_s;
            overflow_r  <= ovf_ev_s;
            underflow_r <= unf_ev_s;
        end
    end

    // Storage array; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; zero while nothing is stored.
            assign rd_data = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rd_data_r;

            // Registered read data: captures the head on an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_r <= {DATA_W{1'b0}};
                end else if (rd_acc_s) begin
                    rd_data_r <= mem_r[rd_ptr_r];
                end
            end

            assign rd_data = rd_data_r;
        end
    endgenerate

`ifdef SYNC_FIFO_STATS_EN
    logic [LVL_W-1:0] peak_r;
    logic [15:0]      drop_r;
    logic [16:0]      drop_sum_s;

    // Drop count counts events on the edge where the pulse is raised; both
    // events in one cycle add two. The extra bit detects saturation.
    always_comb begin
        drop_sum_s = {1'b0, drop_r} + {16'h0000, ovf_ev_s} + {16'h0000, unf_ev_s};
    end

    // Statistics registers; stats_clr wins over updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r <= {LVL_W{1'b0}};
            drop_r <= 16'h0000;
        end else if (stats_clr) begin
            peak_r <= {LVL_W{1'b0}};
            drop_r <= 16'h0000;
        end else begin
            if (level_r > peak_r) begin
                peak_r <= level_r;
            end
            drop_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

    assign peak_level = peak_r;
    assign drop_cnt   = drop_r;
`else
    logic unused_stats_clr_s;
    assign unused_stats_clr_s = stats_clr;
    assign peak_level         = {LVL_W{1'b0}};
    assign drop_cnt           = 16'h0000;
`endif

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (level_r >= LVL_AF);
    assign almost_empty = (level_r <= LVL_AE);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
    assign level        = level_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl. Two instances share the stimulus:
//   u0: DEPTH=5, FWFT=0, AF_THRESH=4, AE_THRESH=1
//   u1: DEPTH=3, FWFT=1, AF_THRESH=2, AE_THRESH=0
// A queue-style reference model (array kept head-first, shifted on pop) gives
// every expected value.
module tb_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_fire = 1'b0;
    logic        rd_fire = 1'b0;
    logic        stats_clr = 1'b0;
    logic [64:0] wr_data = '0;

    logic        full0, af0, ovf0, empty0, ae0, unf0;
    logic [64:0] rd0;
    logic [2:0]  lvl0, pk0;
    logic [15:0] dc0;
    logic        full1, af1, ovf1, empty1, ae1, unf1;
    logic [64:0] rd1;
    logic [1:0]  lvl1, pk1;
    logic [15:0] dc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_W(65), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .wr_fire(wr_fire), .wr_data(wr_data),
        .full(full0), .almost_full(af0), .overflow(ovf0),
        .rd_fire(rd_fire), .rd_data(rd0), .empty(empty0), .almost_empty(ae0),
        .underflow(unf0), .level(lvl0), .stats_clr(stats_clr),
        .peak_level(pk0), .drop_cnt(dc0)
    );

    sync_fifo_ctrl #(.DATA_W(65), .DEPTH(3), .AF_THRESH(2), .AE_THRESH(0), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .wr_fire(wr_fire), .wr_data(wr_data),
        .full(full1), .almost_full(af1), .overflow(ovf1),
        .rd_fire(rd_fire), .rd_data(rd1), .empty(empty1), .almost_empty(ae1),
        .underflow(unf1), .level(lvl1), .stats_clr(stats_clr),
        .peak_level(pk1), .drop_cnt(dc1)
    );

    // Reference model state, per instance
    int          dep [2] = '{5, 3};
    int          afth[2] = '{4, 2};
    int          aeth[2] = '{1, 0};
    int          fw  [2] = '{0, 1};
    logic [64:0] mq  [2][8];
    int          mcnt[2] = '{0, 0};
    logic [64:0] mrd [2];
    int          mov [2] = '{0, 0};
    int          mun [2] = '{0, 0};
    int          mpk [2] = '{0, 0};
    int          mdrop[2] = '{0, 0};

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic wf, input logic rf,
                                input logic sc, input logic [64:0] wd);
        for (int i = 0; i < 2; i++) begin
            int pre;
            int ove;
            int une;
            logic [64:0] head;
            pre = mcnt[i];
            ove = (wf && pre == dep[i]) ? 1 : 0;
            une = (rf && pre == 0) ? 1 : 0;
            if (r) begin
                mcnt[i] = 0; mrd[i] = '0; mov[i] = 0; mun[i] = 0;
                mpk[i] = 0; mdrop[i] = 0;
            end else begin
                if (sc) begin
                    mpk[i] = 0; mdrop[i] = 0;
                end else begin
                    if (pre > mpk[i]) mpk[i] = pre;
                    mdrop[i] = mdrop[i] + ove + une;
                    if (mdrop[i] > 65535) mdrop[i] = 65535;
                end
                mov[i] = ove;
                mun[i] = une;
                if (rf && pre > 0) begin
                    head = mq[i][0];
                    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                    mcnt[i] = mcnt[i] - 1;
                    if (fw[i] == 0) mrd[i] = head;
                end
                if (wf && pre < dep[i]) begin
                    mq[i][mcnt[i]] = wd;
                    mcnt[i] = mcnt[i] + 1;
                end
            end
        end
    endtask

    task automatic chk_inst(input int i, input logic [64:0] lvl, input logic f,
                            input logic e, input logic afl, input logic ael,
                            input logic ov, input logic un, input logic [64:0] rd,
                            input logic [64:0] pk, input logic [15:0] dc);
        logic [64:0] exp_rd;
        int exp_pk;
        int exp_dc;
        if (fw[i] != 0) exp_rd = (mcnt[i] > 0) ? mq[i][0] : 65'h0;
        else            exp_rd = mrd[i];
`ifdef SYNC_FIFO_STATS_EN
        exp_pk = mpk[i];
        exp_dc = mdrop[i];
`else
        exp_pk = 0;
        exp_dc = 0;
`endif
        chk($sformatf("u%0d.level", i),        lvl,        65'(mcnt[i]));
        chk($sformatf("u%0d.full", i),         65'(f),     65'(mcnt[i] == dep[i]));
        chk($sformatf("u%0d.empty", i),        65'(e),     65'(mcnt[i] == 0));
        chk($sformatf("u%0d.almost_full", i),  65'(afl),   65'(mcnt[i] >= afth[i]));
        chk($sformatf("u%0d.almost_empty", i), 65'(ael),   65'(mcnt[i] <= aeth[i]));
        chk($sformatf("u%0d.overflow", i),     65'(ov),    65'(mov[i]));
        chk($sformatf("u%0d.underflow", i),    65'(un),    65'(mun[i]));
        chk($sformatf("u%0d.rd_data", i),      rd,         exp_rd);
        chk($sformatf("u%0d.peak_level", i),   pk,         65'(exp_pk));
        chk($sformatf("u%0d.drop_cnt", i),     65'(dc),    65'(exp_dc));
    endtask

    // One clock cycle: drive, clock, update model, sample 1 ns after the edge.
    task automatic step(input logic r, input logic wf, input logic rf,
                        input logic sc, input logic [64:0] wd);
        rst = r; wr_fire = wf; rd_fire = rf; stats_clr = sc; wr_data = wd;
        @(posedge clk);
        model_update(r, wf, rf, sc, wd);
        #1;
        chk_inst(0, 65'(lvl0), full0, empty0, af0, ae0, ovf0, unf0, rd0, 65'(pk0), dc0);
        chk_inst(1, 65'(lvl1), full1, empty1, af1, ae1, ovf1, unf1, rd1, 65'(pk1), dc1);
    endtask

    initial begin
        logic [95:0] r96;
        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 65'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 65'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 65'h0);
        // Fill with 1..5 (u0 reaches full; u1 overflows on the 4th and 5th)
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 65'(k));
        // Drain five times
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 65'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 65'h0);
        // Full boundary: simultaneous write/read while full, 0xAA dropped
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 65'h10 + 65'(k));
        step(1'b0, 1'b1, 1'b1, 1'b0, 65'hAA);
        step(1'b0, 1'b0, 1'b0, 1'b0, 65'h0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 65'h0);
        // Empty boundary: simultaneous write/read while empty
        step(1'b0, 1'b1, 1'b1, 1'b0, 65'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 65'h0);
        // Wrap-around at level 2
        step(1'b0, 1'b1, 1'b0, 1'b0, 65'h55);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 65'h100 + 65'(k));
        // Statistics clear, then reset at level 3 with a write in flight
        step(1'b0, 1'b0, 1'b0, 1'b1, 65'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 65'h77);
        step(1'b1, 1'b1, 1'b0, 1'b0, 65'h99);
        step(1'b0, 1'b0, 1'b0, 1'b0, 65'h0);
        // Randomized traffic: write-heavy, then read-heavy, then balanced
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 150; k++) begin
                int wp;
                logic wf;
                logic rf;
                logic sc;
                logic rr;
                wp = (ph == 0) ? 3 : ((ph == 1) ? 1 : 2);
                wf = ($urandom_range(0, 3) < wp);
                rf = ($urandom_range(0, 3) < (4 - wp));
                sc = ($urandom_range(0, 31) == 0);
                rr = ($urandom_range(0, 63) == 0);
                r96 = {$urandom(), $urandom(), $urandom()};
                step(rr, wf, rf, sc, r96[64:0]);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
